// File: rtl/result_accumulator_if.sv
// result_accumulator_if: sample-in / block-out handshake bundle for the result accumulator.
interface result_accumulator_if #(
    parameter int DATA_WIDTH  = 18,
    parameter int COUNT_WIDTH = 8
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + COUNT_WIDTH;
    logic                    in_valid;
    logic [2*DATA_WIDTH-1:0] in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    out_sum;
    logic [COUNT_WIDTH-1:0]  out_count;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_sum, out_count);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_sum, out_count);
endinterface

// File: rtl/result_accumulator.sv
// result_accumulator: sums blocks of unsigned product samples and holds each block result until taken.
module result_accumulator #(
    parameter int DATA_WIDTH  = 18,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [COUNT_WIDTH-1:0] block_length,
    output logic                   busy,
    result_accumulator_if.slave    bus
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + COUNT_WIDTH;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
    logic                   out_valid_q, in_ready_q;
    logic                   accept;
    logic [ACC_WIDTH-1:0]   sample;
    always_comb begin
        accept  = bus.in_valid && in_ready_q && !clear;
        sample  = ACC_WIDTH'(bus.in_data);
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == HOLD) begin
            state_d = bus.out_ready ? IDLE : HOLD;
        end else if (accept) begin
            // A zero length is treated as a single-sample block
            if (state_q == IDLE) begin
                len_d = (block_length == '0) ? COUNT_WIDTH'(1) : block_length;
                acc_d = sample;
                cnt_d = COUNT_WIDTH'(1);
            end else begin
                acc_d = acc_q + sample;
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
            state_d = (cnt_d == len_d) ? HOLD : ACCUM;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= (state_d == HOLD);
            in_ready_q  <= (state_d != HOLD);
        end
    end
    // The accumulator itself is frozen in HOLD, so it doubles as the result register
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 18, giving the width of each multiplier operand; samples are 2*DATA_WIDTH bits.
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 8, giving the width of the block-length and sample-count fields.
REQ-003 The module SHALL derive local parameter ACC_WIDTH = 2*DATA_WIDTH+COUNT_WIDTH.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port clear, input, 1 bit: synchronous abort of the current block.
REQ-007 The module SHALL have port block_length, input, COUNT_WIDTH bits: number of samples per block.
REQ-008 The module SHALL have port in_valid, input, 1 bit: in_data holds a sample.
REQ-009 The module SHALL have port in_data, input, 2*DATA_WIDTH bits: unsigned product sample from the upstream multiply-add pipeline.
REQ-010 The module SHALL have port in_ready, output, 1 bit: the accumulator can accept a sample this cycle.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_sum and out_count hold a completed block.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts the block.
REQ-013 The module SHALL have port out_sum, output, ACC_WIDTH bits: unsigned block sum.
REQ-014 The module SHALL have port out_count, output, COUNT_WIDTH bits: number of samples summed.
REQ-015 The module SHALL have port busy, output, 1 bit: high in ACCUM or HOLD.

Function
REQ-016 A sample SHALL be accepted on a rising edge only when in_valid=1, in_ready=1 and clear=0.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL be registered, with no combinational path from in_valid or out_ready.
REQ-019 In IDLE, an accepted sample SHALL latch block_length as the block length, load the accumulator with the zero-extended in_data, set the count to 1 and move to ACCUM.
REQ-020 A latched length of 0 SHALL be treated as 1.
REQ-021 Changes on block_length after latching SHALL be ignored until the next block starts.
REQ-022 If the block length is 1, the first accepted sample SHALL move the FSM directly from IDLE to HOLD.
REQ-023 In ACCUM, each accepted sample SHALL add the zero-extended in_data to the accumulator and increment the count.
REQ-024 The accepted sample that makes the count equal the latched length SHALL move the FSM to HOLD.
REQ-025 Cycles with in_valid=0 SHALL leave the accumulator, count and state unchanged.
REQ-026 out_valid SHALL rise on the clock edge that accepts the final sample of the block, so it is visible in the following cycle (latency 1).
REQ-027 out_sum and out_count SHALL be registered and stable while out_valid=1.
REQ-028 In HOLD, out_valid=1 and out_ready=1 on a rising edge SHALL return the FSM to IDLE, clear out_valid and set in_ready=1.
REQ-029 While out_ready=0 in HOLD, the module SHALL remain in HOLD indefinitely with all outputs unchanged.
REQ-030 The accumulator SHALL never overflow: ACC_WIDTH covers (2^COUNT_WIDTH-1)*(2^(2*DATA_WIDTH)-1), and arithmetic SHALL be unsigned and non-saturating.
REQ-031 clear=1 SHALL have priority over every other input: on that edge the FSM goes to IDLE, accumulator and count go to 0, out_valid goes to 0 and any concurrent sample is discarded.
REQ-032 clear SHALL apply in any state, including HOLD, where it drops the pending block.
REQ-033 busy SHALL be 1 exactly when the state is ACCUM or HOLD.

Reset
REQ-034 While reset=0, the module SHALL asynchronously force state=IDLE, accumulator=0, count=0, out_sum=0, out_count=0, out_valid=0, in_ready=1 and busy=0, regardless of clock.
REQ-035 After reset deasserts, the first sample SHALL be accepted on the first rising edge with in_valid=1.
REQ-036 Reset asserted mid-block or in HOLD SHALL discard all partial or pending results.

Verification (DATA_WIDTH=8, COUNT_WIDTH=4, ACC_WIDTH=20)
REQ-037 The bench SHALL check: reset low -> out_valid=0, out_sum=0, out_count=0, in_ready=1, busy=0, with no clock edge required.
REQ-038 The bench SHALL check: length 4, samples 10,20,30,40 on consecutive cycles -> out_valid=1 the cycle after 40, out_sum=100, out_count=4; with out_ready held 0 for 3 cycles the outputs stay stable and in_ready=0; after the out_ready=1 edge, out_valid=0 and in_ready=1.
REQ-039 The bench SHALL check: length 15, all samples 0xFFFF -> out_sum=0xEFFF1 (983025), out_count=15, with no wrap.
REQ-040 The bench SHALL check: length 3, samples 5,0,9 separated by 2 idle cycles each, with block_length changed to 7 mid-block -> out_sum=14, out_count=3.
REQ-041 The bench SHALL check: length 4, clear after 2 samples (a sample presented with clear is discarded), then length 2 with samples 5,6 -> out_sum=11, out_count=2; and length 0 with sample 7 -> out_sum=7, out_count=1.
REQ-042 The bench SHALL check: reset pulsed low while in HOLD -> out_valid falls immediately, then the next block of length 1 with sample 3 gives out_sum=3.
